// File: rtl/alu_pkg.sv
// Shared types and sizing for the ALU issue path: op encoding, response record
// and the per-op tracking record carried through the latency pipe.
package alu_pkg;

  localparam int IN_WL   = 15;
  localparam int OUT_WL  = 16;
  localparam int ALU_LAT = 2;
  localparam int DEPTH   = 4;
  localparam int TAG_W   = 4;
  localparam int PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W   = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {
    ALU_ADD = 2'b00,
    ALU_SUB = 2'b01,
    ALU_MUL = 2'b10,
    ALU_DIV = 2'b11
  } alu_op_e;

  typedef struct packed {
    logic [TAG_W-1:0]         tag;
    alu_op_e                  op;
    logic signed [OUT_WL-1:0] r;
    logic                     err;
  } alu_rsp_t;

  typedef struct packed {
    logic             vld;
    logic [TAG_W-1:0] tag;
    alu_op_e          op;
    logic             dz;
  } alu_trk_t;

  function automatic logic is_div_zero(alu_op_e op, logic [IN_WL-1:0] b);
    return (op == ALU_DIV) && (b == '0);
  endfunction

endpackage

// File: rtl/alu_op_issuer_if.sv
// Request, ALU and response buses of the op issuer; the issuer side uses the
// master modport, the host/ALU environment the slave modport.
interface alu_op_issuer_if;
  import alu_pkg::*;

  logic              req_valid_i;
  logic              req_ready_o;
  alu_op_e           req_op_i;
  logic [IN_WL-1:0]  req_a_i;
  logic [IN_WL-1:0]  req_b_i;
  logic [TAG_W-1:0]  req_tag_i;

  logic              alu_vld_o;
  alu_op_e           alu_cmd_o;
  logic [IN_WL-1:0]  alu_a_o;
  logic [IN_WL-1:0]  alu_b_o;
  logic [OUT_WL-1:0] alu_r_i;

  logic              rsp_valid_o;
  logic              rsp_ready_i;
  logic [TAG_W-1:0]  rsp_tag_o;
  alu_op_e           rsp_op_o;
  logic [OUT_WL-1:0] rsp_r_o;
  logic              rsp_err_o;

  logic              busy_o;

  modport master (
    input  req_valid_i, req_op_i, req_a_i, req_b_i, req_tag_i,
    output req_ready_o,
    output alu_vld_o, alu_cmd_o, alu_a_o, alu_b_o,
    input  alu_r_i,
    output rsp_valid_o, rsp_tag_o, rsp_op_o, rsp_r_o, rsp_err_o,
    input  rsp_ready_i,
    output busy_o
  );

  modport slave (
    output req_valid_i, req_op_i, req_a_i, req_b_i, req_tag_i,
    input  req_ready_o,
    input  alu_vld_o, alu_cmd_o, alu_a_o, alu_b_o,
    output alu_r_i,
    input  rsp_valid_o, rsp_tag_o, rsp_op_o, rsp_r_o, rsp_err_o,
    output rsp_ready_i,
    input  busy_o
  );

endinterface

// File: rtl/alu_rsp_fifo.sv
// In-order response FIFO; head entry is presented combinationally and a push
// into a full FIFO is accepted when the same cycle also pops.
module alu_rsp_fifo
  import alu_pkg::*;
(
  input  logic             clk_i,
  input  logic             rstb,
  input  logic             push,
  input  alu_rsp_t         push_data,
  input  logic             pop,
  output alu_rsp_t         pop_data,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  alu_rsp_t         mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty    = (count == '0);
  assign full     = (count == CNT_W'(DEPTH));
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);
  assign pop_data = mem[rd_ptr];

  // Power-of-two depth lets the pointers wrap by plain overflow.
  always_ff @(posedge clk_i) begin
    if (!rstb) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/alu_op_issuer.sv
// Issues tagged ops to the ALU, tracks them for the fixed ALU latency and
// queues results in order; a credit counter keeps the response FIFO from overflowing.
module alu_op_issuer
  import alu_pkg::*;
(
  input  logic            clk_i,
  input  logic            rstb,
  alu_op_issuer_if.master bus
);

  logic [CNT_W-1:0] cnt;
  logic             accept;
  logic             pop;
  alu_trk_t         issue_q;
  alu_trk_t         pipe_q [ALU_LAT];
  alu_trk_t         exit_q;
  alu_rsp_t         push_data;
  alu_rsp_t         head;
  logic             fifo_full;
  logic             fifo_empty;
  logic [CNT_W-1:0] fifo_count;

  assign bus.req_ready_o = (cnt < CNT_W'(DEPTH));
  assign accept          = bus.req_valid_i && bus.req_ready_o;
  assign pop             = bus.rsp_valid_o && bus.rsp_ready_i;
  assign bus.busy_o      = (cnt != '0);

  // One credit per op from acceptance until its response is popped.
  always_ff @(posedge clk_i) begin
    if (!rstb) begin
      cnt <= '0;
    end else if (accept && !pop) begin
      cnt <= cnt + CNT_W'(1);
    end else if (!accept && pop) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  // The issue register doubles as the head of the tracking pipe, so its exit
  // lines up with the cycle in which the ALU result is valid.
  always_ff @(posedge clk_i) begin
    if (!rstb) begin
      bus.alu_cmd_o <= ALU_ADD;
      bus.alu_a_o   <= '0;
      bus.alu_b_o   <= '0;
      issue_q       <= '0;
      for (int i = 0; i < ALU_LAT; i++) pipe_q[i] <= '0;
    end else begin
      issue_q.vld <= accept;
      if (accept) begin
        bus.alu_cmd_o <= bus.req_op_i;
        bus.alu_a_o   <= bus.req_a_i;
        bus.alu_b_o   <= bus.req_b_i;
        issue_q.tag   <= bus.req_tag_i;
        issue_q.op    <= bus.req_op_i;
        issue_q.dz    <= is_div_zero(bus.req_op_i, bus.req_b_i);
      end
      pipe_q[0] <= issue_q;
      for (int i = 1; i < ALU_LAT; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  assign bus.alu_vld_o = issue_q.vld;
  assign exit_q        = pipe_q[ALU_LAT-1];

  always_comb begin
    push_data     = '0;
    push_data.tag = exit_q.tag;
    push_data.op  = exit_q.op;
    push_data.r   = exit_q.dz ? '0 : $signed(bus.alu_r_i);
    push_data.err = exit_q.dz;
  end

  alu_rsp_fifo u_fifo (
    .clk_i     (clk_i),
    .rstb      (rstb),
    .push      (exit_q.vld),
    .push_data (push_data),
    .pop       (pop),
    .pop_data  (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign bus.rsp_valid_o = !fifo_empty;
  assign bus.rsp_tag_o   = head.tag;
  assign bus.rsp_op_o    = head.op;
  assign bus.rsp_r_o     = head.r;
  assign bus.rsp_err_o   = head.err;

  // Credits must make a push into a full FIFO impossible unless it also pops.
  a_push_room: assert property (@(posedge clk_i) disable iff (!rstb)
    !(fifo_full && exit_q.vld && !pop));
  a_count_le_cnt: assert property (@(posedge clk_i) disable iff (!rstb)
    fifo_count <= cnt);

endmodule
